// File: rtl/sa_autosa_csc_multi_reg_pkg.sv
// Shared definitions for the multi-group control/status register block.
// Holds the register offsets, the INTR_STATUS bit positions, the POINTER
// field layout and the decoded register-select enum.
package sa_autosa_csc_multi_reg_pkg;

  // Register byte offsets
  localparam logic [11:0] OFF_STATUS      = 12'h000;
  localparam logic [11:0] OFF_POINTER     = 12'h004;
  localparam logic [11:0] OFF_OP_ENABLE   = 12'h008;
  localparam logic [11:0] OFF_INTR_STATUS = 12'h00C;
  // Status words for groups 2 and up live at 0x100 + 4*(g/2)
  localparam logic [3:0]  OFF_STATUS_HI_PAGE = 4'h1;

  // INTR_STATUS bit positions
  localparam int INTR_DONE_BIT = 0;
  localparam int INTR_ERR_BIT  = 1;

  // POINTER field layout
  localparam int PTR_PROD_LSB = 0;
  localparam int PTR_CONS_LSB = 16;
  localparam int PTR_FIELD_W  = 16;

  typedef enum logic [2:0] {
    SEL_NONE      = 3'd0,
    SEL_STATUS    = 3'd1,
    SEL_POINTER   = 3'd2,
    SEL_OP_ENABLE = 3'd3,
    SEL_INTR      = 3'd4
  } reg_sel_e;

  // Assemble the POINTER read word from zero-extended fields
  function automatic logic [31:0] pack_pointer(input logic [PTR_FIELD_W-1:0] cons,
                                               input logic [PTR_FIELD_W-1:0] prod);
    logic [31:0] word;
    word = 32'h0000_0000;
    word[PTR_CONS_LSB +: PTR_FIELD_W] = cons;
    word[PTR_PROD_LSB +: PTR_FIELD_W] = prod;
    return word;
  endfunction

endpackage

// File: rtl/sa_autosa_csc_group_ring.sv
// Per-group busy tracking and the hardware consumer ring.
// Ports:
//   autosa_core_clk / autosa_core_rstn : clock, async active-low reset
//   producer  : group targeted by an enable request
//   en_req    : enable request for the producer group (one cycle)
//   op_done   : completion pulse for the consumer group
//   op_en     : per-group busy level (registered)
//   consumer  : active group, advances on every accepted completion
//   done_set  : completion accepted this cycle
//   err_set   : request or completion rejected this cycle
module sa_autosa_csc_group_ring
  import sa_autosa_csc_multi_reg_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int PTR_W      = $clog2(NUM_GROUPS)
) (
  input  logic                  autosa_core_clk,
  input  logic                  autosa_core_rstn,
  input  logic [PTR_W-1:0]      producer,
  input  logic                  en_req,
  input  logic                  op_done,
  output logic [NUM_GROUPS-1:0] op_en,
  output logic [PTR_W-1:0]      consumer,
  output logic                  done_set,
  output logic                  err_set
);

  localparam logic [NUM_GROUPS-1:0] ONE_HOT_LSB = {{(NUM_GROUPS-1){1'b0}}, 1'b1};

  logic [NUM_GROUPS-1:0] op_en_r;
  logic [NUM_GROUPS-1:0] op_en_nxt_s;
  logic [PTR_W-1:0]      consumer_r;
  logic [PTR_W-1:0]      consumer_nxt_s;
  logic                  done_ok_s;
  logic                  en_ok_s;

  // Accept/reject decisions and next busy/ring state.
  // A group whose completion is accepted this cycle is still busy in op_en_r,
  // so a same-cycle enable to it is rejected and the clear wins.
  always_comb begin
    done_ok_s      = op_done & op_en_r[consumer_r];
    en_ok_s        = en_req & ~op_en_r[producer];
    op_en_nxt_s    = (op_en_r & ~(done_ok_s ? (ONE_HOT_LSB << consumer_r) : {NUM_GROUPS{1'b0}}))
                   | (en_ok_s ? (ONE_HOT_LSB << producer) : {NUM_GROUPS{1'b0}});
    consumer_nxt_s = done_ok_s ? (consumer_r + 1'b1) : consumer_r;
    done_set       = done_ok_s;
    err_set        = (op_done & ~op_en_r[consumer_r]) | (en_req & op_en_r[producer]);
  end

  // Busy vector and consumer ring registers
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      op_en_r    <= {NUM_GROUPS{1'b0}};
      consumer_r <= {PTR_W{1'b0}};
    end else begin
      op_en_r    <= op_en_nxt_s;
      consumer_r <= consumer_nxt_s;
    end
  end

  assign op_en    = op_en_r;
  assign consumer = consumer_r;

endmodule

// File: rtl/sa_autosa_csc_multi_reg.sv
// Multi-group control/status register block: decode, read mux, producer
// pointer and sticky interrupt flags. Busy/ring tracking is in
// sa_autosa_csc_group_ring.
// Ports:
//   autosa_core_clk / autosa_core_rstn : clock, async active-low reset
//   reg_offset / reg_wr_data / reg_wr_en : register write bus
//   reg_rd_data : combinational read data for reg_offset
//   producer / consumer : software-selected and hardware-active group
//   op_en   : per-group busy level
//   op_done : completion pulse for the consumer group
//   status  : read-only per-group status fields
//   irq     : level interrupt, registered done | err
// Build option: AUTOSA_CSC_INVALID_WR_ERR_EN makes writes to STATUS or to
// unmapped offsets raise INTR_STATUS.err; otherwise they are dropped.
module sa_autosa_csc_multi_reg
  import sa_autosa_csc_multi_reg_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int STATUS_W   = 2,
  parameter int PTR_W      = $clog2(NUM_GROUPS)
) (
  input  logic                           autosa_core_clk,
  input  logic                           autosa_core_rstn,
  input  logic [11:0]                    reg_offset,
  input  logic [31:0]                    reg_wr_data,
  input  logic                           reg_wr_en,
  output logic [31:0]                    reg_rd_data,
  output logic [PTR_W-1:0]               producer,
  output logic [PTR_W-1:0]               consumer,
  output logic [NUM_GROUPS-1:0]          op_en,
  input  logic                           op_done,
  input  logic [NUM_GROUPS*STATUS_W-1:0] status,
  output logic                           irq
);

  localparam int NUM_WORDS = (NUM_GROUPS + 1) / 2;

  reg_sel_e         sel_s;
  logic [5:0]       word_idx_s;
  logic             hi_status_hit_s;
  logic [31:0]      status_word_s [NUM_WORDS];
  logic [31:0]      status_rd_s;
  logic [31:0]      intr_word_s;
  logic [31:0]      rd_data_s;
  logic [PTR_W-1:0] producer_r;
  logic [PTR_W-1:0] consumer_s;
  logic             done_r;
  logic             err_r;
  logic             irq_r;
  logic             ptr_wr_s;
  logic             en_req_s;
  logic             w1c_done_s;
  logic             w1c_err_s;
  logic             inv_err_s;
  logic             ring_done_set_s;
  logic             ring_err_set_s;
  logic             done_nxt_s;
  logic             err_nxt_s;
  logic             unused_wr_data_s;

  // Word 0 sits at 0x000; higher status words start on the 0x100 page
  assign hi_status_hit_s = (reg_offset[11:8] == OFF_STATUS_HI_PAGE)
                        && (reg_offset[1:0] == 2'b00)
                        && (reg_offset[7:2] != 6'd0)
                        && (32'(reg_offset[7:2]) < 32'(NUM_WORDS));

  // Offset decode
  always_comb begin
    sel_s      = SEL_NONE;
    word_idx_s = 6'd0;
    if (reg_offset == OFF_STATUS) begin
      sel_s = SEL_STATUS;
    end else if (reg_offset == OFF_POINTER) begin
      sel_s = SEL_POINTER;
    end else if (reg_offset == OFF_OP_ENABLE) begin
      sel_s = SEL_OP_ENABLE;
    end else if (reg_offset == OFF_INTR_STATUS) begin
      sel_s = SEL_INTR;
    end else if (hi_status_hit_s) begin
      sel_s      = SEL_STATUS;
      word_idx_s = reg_offset[7:2];
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Pack two groups per status word, low group in [15:0], unused bits zero
  always_comb begin
    for (int w = 0; w < NUM_WORDS; w++) begin
      status_word_s[w] = 32'h0000_0000;
    end
    for (int g = 0; g < NUM_GROUPS; g++) begin
      status_word_s[g/2][16*(g%2) +: STATUS_W] = status[g*STATUS_W +: STATUS_W];
    end
  end

  // Read data mux; unmapped offsets and write-only registers read zero
  always_comb begin
    status_rd_s = 32'h0000_0000;
    for (int w = 0; w < NUM_WORDS; w++) begin
      status_rd_s = status_rd_s | ((word_idx_s == 6'(w)) ? status_word_s[w] : 32'h0000_0000);
    end
    intr_word_s                = 32'h0000_0000;
    intr_word_s[INTR_DONE_BIT] = done_r;
    intr_word_s[INTR_ERR_BIT]  = err_r;
    rd_data_s                  = 32'h0000_0000;
    case (sel_s)
      SEL_STATUS:  rd_data_s = status_rd_s;
      SEL_POINTER: rd_data_s = pack_pointer(16'(consumer_s), 16'(producer_r));
      SEL_INTR:    rd_data_s = intr_word_s;
      default:     rd_data_s = 32'h0000_0000;
    endcase
  end

  assign ptr_wr_s   = reg_wr_en && (sel_s == SEL_POINTER);
  assign en_req_s   = reg_wr_en && (sel_s == SEL_OP_ENABLE) && reg_wr_data[0];
  assign w1c_done_s = reg_wr_en && (sel_s == SEL_INTR) && reg_wr_data[INTR_DONE_BIT];
  assign w1c_err_s  = reg_wr_en && (sel_s == SEL_INTR) && reg_wr_data[INTR_ERR_BIT];

`ifdef AUTOSA_CSC_INVALID_WR_ERR_EN
  assign inv_err_s = reg_wr_en && ((sel_s == SEL_STATUS) || (sel_s == SEL_NONE));
`else
  assign inv_err_s = 1'b0;
`endif

  // Only a few write-data bits carry meaning
  assign unused_wr_data_s = &{1'b0, reg_wr_data};

  sa_autosa_csc_group_ring #(
    .NUM_GROUPS (NUM_GROUPS),
    .PTR_W      (PTR_W)
  ) u_ring (
    .autosa_core_clk  (autosa_core_clk),
    .autosa_core_rstn (autosa_core_rstn),
    .producer         (producer_r),
    .en_req           (en_req_s),
    .op_done          (op_done),
    .op_en            (op_en),
    .consumer         (consumer_s),
    .done_set         (ring_done_set_s),
    .err_set          (ring_err_set_s)
  );

  // Hardware set is OR-ed after the W1C clear so a same-cycle set wins
  assign done_nxt_s = ring_done_set_s | (done_r & ~w1c_done_s);
  assign err_nxt_s  = ring_err_set_s | inv_err_s | (err_r & ~w1c_err_s);

  // Producer pointer, sticky interrupt flags and irq register
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      producer_r <= {PTR_W{1'b0}};
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      if (ptr_wr_s) begin
        producer_r <= reg_wr_data[PTR_W-1:0];
      end else begin
        producer_r <= producer_r;
      end
      done_r <= done_nxt_s;
      err_r  <= err_nxt_s;
      irq_r  <= done_nxt_s | err_nxt_s;
    end
  end

  assign reg_rd_data = rd_data_s;
  assign producer    = producer_r;
  assign consumer    = consumer_s;
  assign irq         = irq_r;

endmodule

// File: tb/tb_sa_autosa_csc_multi_reg.sv
// Directed bench: one 4-group and one 2-group instance share clock and reset.
module tb_sa_autosa_csc_multi_reg;

  logic        clk;
  logic        rstn;

  // 4-group instance
  logic [11:0] off4;
  logic [31:0] wd4;
  logic        we4;
  logic [31:0] rd4;
  logic [1:0]  prod4;
  logic [1:0]  cons4;
  logic [3:0]  open4;
  logic        done4;
  logic [7:0]  stat4;
  logic        irq4;

  // 2-group instance
  logic [11:0] off2;
  logic [31:0] wd2;
  logic        we2;
  logic [31:0] rd2;
  logic [0:0]  prod2;
  logic [0:0]  cons2;
  logic [1:0]  open2;
  logic        done2;
  logic [3:0]  stat2;
  logic        irq2;

  int total;
  int bad;
  logic [31:0] r;
  logic [31:0] inv_exp;

  sa_autosa_csc_multi_reg #(.NUM_GROUPS(4), .STATUS_W(2)) u_dut4 (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn),
    .reg_offset(off4), .reg_wr_data(wd4), .reg_wr_en(we4), .reg_rd_data(rd4),
    .producer(prod4), .consumer(cons4), .op_en(open4), .op_done(done4),
    .status(stat4), .irq(irq4)
  );

  sa_autosa_csc_multi_reg #(.NUM_GROUPS(2), .STATUS_W(2)) u_dut2 (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn),
    .reg_offset(off2), .reg_wr_data(wd2), .reg_wr_en(we2), .reg_rd_data(rd2),
    .producer(prod2), .consumer(cons2), .op_en(open2), .op_done(done2),
    .status(stat2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr4(input logic [11:0] o, input logic [31:0] d);
    off4 = o; wd4 = d; we4 = 1'b1;
    step();
    we4 = 1'b0; wd4 = 32'h0;
  endtask

  task automatic wr2(input logic [11:0] o, input logic [31:0] d);
    off2 = o; wd2 = d; we2 = 1'b1;
    step();
    we2 = 1'b0; wd2 = 32'h0;
  endtask

  task automatic rdb4(input logic [11:0] o, output logic [31:0] d);
    off4 = o; #1; d = rd4;
  endtask

  task automatic rdb2(input logic [11:0] o, output logic [31:0] d);
    off2 = o; #1; d = rd2;
  endtask

  task automatic pulse4();
    done4 = 1'b1; step(); done4 = 1'b0;
  endtask

  task automatic pulse2();
    done2 = 1'b1; step(); done2 = 1'b0;
  endtask

  task automatic test_reset();
    step();
    rdb4(12'h004, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_ptr4: got %h want %h", r, 32'h0); end
    total++; if (irq4 !== 1'b0) begin bad++; $display("FAIL rst_irq4: got %b want 0", irq4); end
    total++; if (open4 !== 4'h0) begin bad++; $display("FAIL rst_open4: got %b want 0000", open4); end
    rdb2(12'h004, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_ptr2: got %h want %h", r, 32'h0); end
    total++; if ({irq2, open2} !== 3'b000) begin bad++; $display("FAIL rst_irq_open2: got %b want 000", {irq2, open2}); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_status_read();
    // dut4 groups: g0=2 g1=3 g2=1 g3=2 ; dut2 groups: g0=3 g1=1
    stat4 = 8'b10_01_11_10;
    stat2 = 4'b01_11;
    rdb4(12'h000, r);
    total++; if (r !== 32'h0003_0002) begin bad++; $display("FAIL stat4_w0: got %h want %h", r, 32'h0003_0002); end
    rdb4(12'h104, r);
    total++; if (r !== 32'h0002_0001) begin bad++; $display("FAIL stat4_w1: got %h want %h", r, 32'h0002_0001); end
    rdb4(12'h100, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL stat4_0x100: got %h want 0", r); end
    rdb4(12'h010, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL undef4_0x010: got %h want 0", r); end
    rdb2(12'h000, r);
    total++; if (r !== 32'h0001_0003) begin bad++; $display("FAIL stat2_w0: got %h want %h", r, 32'h0001_0003); end
    rdb2(12'h104, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL stat2_0x104: got %h want 0", r); end
  endtask

  task automatic test_enable_err();
    wr4(12'h004, 32'hFFFF_FFFE);
    rdb4(12'h004, r);
    total++; if (r !== 32'h0000_0002) begin bad++; $display("FAIL ptr4_wr: got %h want %h", r, 32'h2); end
    wr4(12'h008, 32'h1);
    total++; if (open4 !== 4'b0100) begin bad++; $display("FAIL en4_g2: got %b want 0100", open4); end
    rdb4(12'h00C, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL intr4_clean: got %h want 0", r); end
    for (int i = 0; i < 3; i++) pulse4();
    rdb4(12'h00C, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL intr4_err: got %h want 2", r); end
    total++; if (irq4 !== 1'b1) begin bad++; $display("FAIL irq4_err: got %b want 1", irq4); end
    total++; if ({cons4, open4} !== 6'b00_0100) begin bad++; $display("FAIL cons_open4_idle: got %b want 000100", {cons4, open4}); end
    wr4(12'h00C, 32'h2);
    rdb4(12'h00C, r);
    total++; if ({irq4, r} !== {1'b0, 32'h0}) begin bad++; $display("FAIL w1c4_err: got %h want 0", {irq4, r}); end
    wr4(12'h008, 32'h0);
    rdb4(12'h00C, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL en4_bit0_zero: got %h want 0", r); end
    wr4(12'h008, 32'h1);
    rdb4(12'h00C, r);
    total++; if ({open4, r} !== {4'b0100, 32'h2}) begin bad++; $display("FAIL en4_busy: got %h want %h", {open4, r}, {4'b0100, 32'h2}); end
    wr4(12'h00C, 32'h3);
  endtask

  task automatic test_ring_wrap();
    wr2(12'h004, 32'h0); wr2(12'h008, 32'h1);
    wr2(12'h004, 32'h1); wr2(12'h008, 32'h1);
    total++; if (open2 !== 2'b11) begin bad++; $display("FAIL en2_both: got %b want 11", open2); end
    pulse2();
    rdb2(12'h004, r);
    total++; if ({open2, r} !== {2'b10, 32'h0001_0001}) begin bad++; $display("FAIL ring2_first: got %h want %h", {open2, r}, {2'b10, 32'h0001_0001}); end
    pulse2();
    rdb2(12'h00C, r);
    total++; if ({cons2, open2, irq2, r} !== {1'b0, 2'b00, 1'b1, 32'h1}) begin bad++; $display("FAIL ring2_wrap: got %h want %h", {cons2, open2, irq2, r}, {1'b0, 2'b00, 1'b1, 32'h1}); end
    wr2(12'h00C, 32'h1);
    rdb2(12'h00C, r);
    total++; if ({irq2, r} !== {1'b0, 32'h0}) begin bad++; $display("FAIL w1c2_done: got %h want 0", {irq2, r}); end
  endtask

  task automatic test_w1c_vs_set();
    wr2(12'h004, 32'h0); wr2(12'h008, 32'h1);
    off2 = 12'h00C; wd2 = 32'h1; we2 = 1'b1; done2 = 1'b1;
    step();
    we2 = 1'b0; done2 = 1'b0;
    rdb2(12'h00C, r);
    total++; if ({cons2, open2, irq2, r} !== {1'b1, 2'b00, 1'b1, 32'h1}) begin bad++; $display("FAIL set_beats_w1c: got %h want %h", {cons2, open2, irq2, r}, {1'b1, 2'b00, 1'b1, 32'h1}); end
    wr2(12'h00C, 32'h3);
  endtask

  task automatic test_same_cycle_clear();
    wr2(12'h004, 32'h1); wr2(12'h008, 32'h1);
    total++; if (open2 !== 2'b10) begin bad++; $display("FAIL en2_g1: got %b want 10", open2); end
    off2 = 12'h008; wd2 = 32'h1; we2 = 1'b1; done2 = 1'b1;
    step();
    we2 = 1'b0; done2 = 1'b0;
    rdb2(12'h00C, r);
    total++; if ({cons2, open2, r} !== {1'b0, 2'b00, 32'h3}) begin bad++; $display("FAIL clear_beats_en: got %h want %h", {cons2, open2, r}, {1'b0, 2'b00, 32'h3}); end
    wr2(12'h00C, 32'h3);
  endtask

  task automatic test_reset_mid();
    wr2(12'h004, 32'h0); wr2(12'h008, 32'h1);
    wr2(12'h004, 32'h1); wr2(12'h008, 32'h1);
    pulse4();   // consumer 0 idle on dut4 -> err, so irq4 is high before reset
    total++; if ({open2, irq4} !== 3'b111) begin bad++; $display("FAIL pre_rst: got %b want 111", {open2, irq4}); end
    #2;
    rstn = 1'b0;
    #1;
    off2 = 12'h00C;
    #1;
    total++; if ({prod2, cons2, open2, irq2, rd2} !== 37'h0) begin bad++; $display("FAIL async_rst2: got %h want 0", {prod2, cons2, open2, irq2, rd2}); end
    total++; if ({prod4, cons4, open4, irq4} !== 9'h0) begin bad++; $display("FAIL async_rst4: got %h want 0", {prod4, cons4, open4, irq4}); end
    done2 = 1'b1; step(); done2 = 1'b0;
    rstn = 1'b1;
    step();
    rdb2(12'h00C, r);
    total++; if ({cons2, r} !== 33'h0) begin bad++; $display("FAIL done_lost_in_rst: got %h want 0", {cons2, r}); end
  endtask

  task automatic test_invalid_write();
`ifdef AUTOSA_CSC_INVALID_WR_ERR_EN
    inv_exp = 32'h2;
`else
    inv_exp = 32'h0;
`endif
    wr4(12'h000, 32'hFFFF_FFFF);
    rdb4(12'h00C, r);
    total++; if (r !== inv_exp) begin bad++; $display("FAIL wr_status_err: got %h want %h", r, inv_exp); end
    wr4(12'h00C, 32'h3);
    wr4(12'h050, 32'h1);
    rdb4(12'h00C, r);
    total++; if (r !== inv_exp) begin bad++; $display("FAIL wr_undef_err: got %h want %h", r, inv_exp); end
    total++; if ({prod4, open4} !== 6'h0) begin bad++; $display("FAIL inv_wr_side: got %b want 0", {prod4, open4}); end
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0;
    off4 = 12'h0; wd4 = 32'h0; we4 = 1'b0; done4 = 1'b0; stat4 = 8'h0;
    off2 = 12'h0; wd2 = 32'h0; we2 = 1'b0; done2 = 1'b0; stat2 = 4'h0;
    test_reset();
    test_status_read();
    test_enable_err();
    test_ring_wrap();
    test_w1c_vs_set();
    test_same_cycle_clear();
    test_reset_mid();
    test_invalid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
